// File: rtl/svlib_str_tokenizer.sv
// Streaming string splitter: cuts an in_last-framed byte stream on a runtime delimiter and queues packed tokens in a FWFT FIFO.
// Optional statistics counters are enabled by defining SVLIB_STR_TOKENIZER_STATS_EN.
module svlib_str_tokenizer #(
    parameter int MAX_LEN    = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = $clog2(MAX_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           delim_char,
    input  logic                 collapse,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_data,
    input  logic                 in_last,
    output logic                 tok_valid,
    input  logic                 tok_ready,
    output logic [8*MAX_LEN-1:0] tok_data,
    output logic [LEN_W-1:0]     tok_len,
    output logic                 tok_trunc,
    output logic                 tok_last
`ifdef SVLIB_STR_TOKENIZER_STATS_EN
    ,
    input  logic                 stats_clr,
    output logic [31:0]          tok_count,
    output logic [15:0]          trunc_count
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int DW = 8 * MAX_LEN;
    localparam int EW = DW + LEN_W + 2;
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0][7:0] r_buf;
    logic [MAX_LEN-1:0][7:0] w_buf_app;
    logic [LEN_W-1:0]        r_len;
    logic [LEN_W-1:0]        w_len_app;
    logic                    r_trunc;
    logic                    w_trunc_app;

    logic [EW-1:0]           r_mem [FIFO_DEPTH];
    logic [PW-1:0]           r_wr;
    logic [PW-1:0]           r_rd;
    logic [PW-1:0]           w_wr_next;
    logic [PW-1:0]           w_rd_next;
    logic [EW-1:0]           r_head;
    logic [EW-1:0]           w_entry;
    logic [EW-1:0]           w_head_next;
    logic                    r_tok_valid;
    logic                    r_in_ready;

    logic w_accept, w_is_delim, w_room, w_append, w_store, w_term, w_push, w_pop;
    logic w_empty_next, w_full_next;

    assign w_accept    = in_valid && r_in_ready;
    assign w_is_delim  = (in_data == delim_char);
    assign w_room      = (r_len < MAX_LEN_L);
    assign w_append    = w_accept && !w_is_delim;
    assign w_store     = w_append && w_room;
    assign w_term      = w_accept && (w_is_delim || in_last);
    // The final token of a string is always emitted, even when empty.
    assign w_push      = w_term && (in_last || (r_len != '0) || !collapse);
    assign w_pop       = r_tok_valid && tok_ready;

    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_byte
            assign w_buf_app[gi] = (w_store && (r_len == LEN_W'(gi))) ? in_data : r_buf[gi];
        end
    endgenerate

    assign w_len_app   = w_store ? (r_len + LEN_W'(1)) : r_len;
    assign w_trunc_app = r_trunc | (w_append && !w_room);
    assign w_entry     = {w_trunc_app, in_last, w_len_app, w_buf_app};

    always_ff @(posedge clk) begin
        if (!rst_n || w_term) begin
            r_buf   <= '0;
            r_len   <= '0;
            r_trunc <= 1'b0;
        end else if (w_accept) begin
            r_buf   <= w_buf_app;
            r_len   <= w_len_app;
            r_trunc <= w_trunc_app;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr[AW-1:0]] <= w_entry;
        end
    end

    assign w_wr_next    = r_wr + PW'(w_push);
    assign w_rd_next    = r_rd + PW'(w_pop);
    assign w_empty_next = (w_wr_next == w_rd_next);
    assign w_full_next  = (w_wr_next[AW] != w_rd_next[AW]) && (w_wr_next[AW-1:0] == w_rd_next[AW-1:0]);
    // A push landing on the next read slot can only happen into an empty FIFO, so it bypasses to the head.
    assign w_head_next  = (w_push && (r_wr[AW-1:0] == w_rd_next[AW-1:0])) ? w_entry
                                                                           : r_mem[w_rd_next[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr        <= '0;
            r_rd        <= '0;
            r_head      <= '0;
            r_tok_valid <= 1'b0;
            r_in_ready  <= 1'b0;
        end else begin
            r_wr        <= w_wr_next;
            r_rd        <= w_rd_next;
            r_head      <= w_empty_next ? '0 : w_head_next;
            r_tok_valid <= !w_empty_next;
            r_in_ready  <= !w_full_next;
        end
    end

    assign in_ready  = r_in_ready;
    assign tok_valid = r_tok_valid;
    assign tok_data  = r_head[DW-1:0];
    assign tok_len   = r_head[DW +: LEN_W];
    assign tok_last  = r_head[EW-2];
    assign tok_trunc = r_head[EW-1];

`ifdef SVLIB_STR_TOKENIZER_STATS_EN
    logic [31:0] r_tok_count;
    logic [15:0] r_trunc_count;

    always_ff @(posedge clk) begin
        if (!rst_n || stats_clr) begin
            r_tok_count   <= '0;
            r_trunc_count <= '0;
        end else if (w_push) begin
            if (r_tok_count != '1) begin
                r_tok_count <= r_tok_count + 32'd1;
            end
            if (w_trunc_app && (r_trunc_count != '1)) begin
                r_trunc_count <= r_trunc_count + 16'd1;
            end
        end
    end

    assign tok_count   = r_tok_count;
    assign trunc_count = r_trunc_count;
`endif

endmodule

// File: tb/tb_svlib_str_tokenizer.sv
// Self-checking bench for svlib_str_tokenizer: queue-based split model checked every cycle, plus literal token expectations.
module tb_svlib_str_tokenizer;

    localparam int TB_ML    = 4;
    localparam int TB_DEPTH = 4;
    localparam int TB_LW    = $clog2(TB_ML + 1);

    typedef struct {
        logic [8*TB_ML-1:0] data;
        int                 len;
        bit                 trunc;
        bit                 last;
    } tok_t;

    logic                 clk;
    logic                 rst_n;
    logic [7:0]           delim_char;
    logic                 collapse;
    logic                 in_valid;
    logic                 in_ready;
    logic [7:0]           in_data;
    logic                 in_last;
    logic                 tok_valid;
    logic                 tok_ready;
    logic [8*TB_ML-1:0]   tok_data;
    logic [TB_LW-1:0]     tok_len;
    logic                 tok_trunc;
    logic                 tok_last;
`ifdef SVLIB_STR_TOKENIZER_STATS_EN
    logic                 stats_clr;
    logic [31:0]          tok_count;
    logic [15:0]          trunc_count;
`endif

    svlib_str_tokenizer #(.MAX_LEN(TB_ML), .FIFO_DEPTH(TB_DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .delim_char (delim_char),
        .collapse   (collapse),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .tok_valid  (tok_valid),
        .tok_ready  (tok_ready),
        .tok_data   (tok_data),
        .tok_len    (tok_len),
        .tok_trunc  (tok_trunc),
        .tok_last   (tok_last)
`ifdef SVLIB_STR_TOKENIZER_STATS_EN
        ,
        .stats_clr  (stats_clr),
        .tok_count  (tok_count),
        .trunc_count(trunc_count)
`endif
    );

    // Model and bookkeeping
    tok_t         exp_q[$];
    logic [7:0]   cur_q[$];
    bit           model_valid = 0;
    bit           m_rst = 0;
    logic [31:0]  m_tok_cnt = 0;
    logic [15:0]  m_trunc_cnt = 0;
    int           n_tests = 0;
    int           n_fail = 0;

    logic [8*TB_ML-1:0] lit_data [0:63];
    int                 lit_len  [0:63];
    bit                 lit_trunc[0:63];
    bit                 lit_last [0:63];
    int                 lit_wr = 0;
    int                 lit_rd = 0;

    int sync_req = 0;
    int sync_ack = 0;
    int timeouts = 0;
    bit rand_mode = 0;
    bit ready_cmd = 0;
    bit gap_en = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        #1;
        tok_ready = rand_mode ? ($urandom_range(0, 3) != 0) : ready_cmd;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic tok_t make_tok(input bit last);
        tok_t t;
        t.data  = '0;
        t.len   = (cur_q.size() > TB_ML) ? TB_ML : cur_q.size();
        t.trunc = (cur_q.size() > TB_ML);
        t.last  = last;
        for (int i = 0; i < t.len; i++) t.data[8*i +: 8] = cur_q[i];
        return t;
    endfunction

    // Compare process: check outputs against the model, then advance the model with this cycle's inputs.
    always @(negedge clk) begin
        tok_t t;
        bit   pop;
        bit   acc;
        bit   pushed;
        if (model_valid) begin
            if (sync_ack != sync_req) begin
                chk("lit_consumed", 64'(lit_rd), 64'(lit_wr));
                chk("drained", 64'(exp_q.size()), 64'd0);
                chk("no_timeout", 64'(timeouts), 64'd0);
                sync_ack = sync_req;
            end
            if (m_rst) begin
                chk("rst_in_ready", 64'(in_ready), 64'd0);
                chk("rst_tok_valid", 64'(tok_valid), 64'd0);
                chk("rst_tok_data", 64'(tok_data), 64'd0);
                chk("rst_tok_len", 64'(tok_len), 64'd0);
                chk("rst_tok_trunc", 64'(tok_trunc), 64'd0);
                chk("rst_tok_last", 64'(tok_last), 64'd0);
            end else begin
                chk("in_ready", 64'(in_ready), 64'(exp_q.size() < TB_DEPTH));
                chk("tok_valid", 64'(tok_valid), 64'(exp_q.size() > 0));
                if (exp_q.size() > 0 && tok_valid) begin
                    chk("head_data", 64'(tok_data), 64'(exp_q[0].data));
                    chk("head_len", 64'(tok_len), 64'(exp_q[0].len));
                    chk("head_trunc", 64'(tok_trunc), 64'(exp_q[0].trunc));
                    chk("head_last", 64'(tok_last), 64'(exp_q[0].last));
                    if (tok_ready && lit_rd < lit_wr) begin
                        chk("lit_data", 64'(tok_data), 64'(lit_data[lit_rd]));
                        chk("lit_len", 64'(tok_len), 64'(lit_len[lit_rd]));
                        chk("lit_trunc", 64'(tok_trunc), 64'(lit_trunc[lit_rd]));
                        chk("lit_last", 64'(tok_last), 64'(lit_last[lit_rd]));
                        lit_rd++;
                    end
                end
            end
`ifdef SVLIB_STR_TOKENIZER_STATS_EN
            chk("tok_count", 64'(tok_count), 64'(m_tok_cnt));
            chk("trunc_count", 64'(trunc_count), 64'(m_trunc_cnt));
`endif
        end

        if (rst_n === 1'b0) begin
            m_rst = 1;
            exp_q.delete();
            cur_q.delete();
            m_tok_cnt = 0;
            m_trunc_cnt = 0;
            model_valid = 1;
        end else if (model_valid) begin
            pop = (exp_q.size() > 0) && (tok_ready === 1'b1);
            acc = (in_valid === 1'b1) && !m_rst && (exp_q.size() < TB_DEPTH);
            m_rst = 0;
            pushed = 0;
            if (pop) exp_q.delete(0);
            if (acc) begin
                if (in_data != delim_char) cur_q.push_back(in_data);
                if (in_data == delim_char || in_last) begin
                    if (in_last || cur_q.size() != 0 || !collapse) begin
                        t = make_tok(in_last);
                        exp_q.push_back(t);
                        pushed = 1;
                    end
                    cur_q.delete();
                end
            end
`ifdef SVLIB_STR_TOKENIZER_STATS_EN
            if (stats_clr) begin
                m_tok_cnt = 0;
                m_trunc_cnt = 0;
            end else if (pushed) begin
                if (m_tok_cnt != 32'hFFFF_FFFF) m_tok_cnt = m_tok_cnt + 1;
                if (t.trunc && m_trunc_cnt != 16'hFFFF) m_trunc_cnt = m_trunc_cnt + 1;
            end
`endif
        end
    end

    task automatic expect_lit(input string s, input bit tr, input bit la);
        logic [8*TB_ML-1:0] d;
        d = '0;
        for (int i = 0; i < s.len(); i++) d[8*i +: 8] = s[i];
        lit_data[lit_wr]  = d;
        lit_len[lit_wr]   = s.len();
        lit_trunc[lit_wr] = tr;
        lit_last[lit_wr]  = la;
        lit_wr++;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic l);
        int  waited;
        bit  done;
        waited = 0;
        done = 0;
        if (gap_en) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        in_last  = l;
        while (!done) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                @(posedge clk);
                #1;
                done = 1;
            end else begin
                @(posedge clk);
                #1;
                waited++;
                if (waited > 200) begin
                    timeouts++;
                    done = 1;
                end
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_str(input string s, input bit last);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], last && (i == s.len() - 1));
    endtask

    task automatic drain_and_sync();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 500) begin
            @(posedge clk);
            #1;
            w++;
        end
        repeat (2) @(posedge clk);
        #1;
        sync_req++;
        w = 0;
        while (sync_ack != sync_req && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
    endtask

    initial begin
        string alph;
        int    n;
        alph       = "ab,;";
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        in_last    = 1'b0;
        delim_char = ",";
        collapse   = 1'b0;
        ready_cmd  = 1'b1;
`ifdef SVLIB_STR_TOKENIZER_STATS_EN
        stats_clr  = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic split
        expect_lit("ab", 0, 0);
        expect_lit("c", 0, 1);
        send_str("ab,c", 1);
        drain_and_sync();

        // Empty tokens with and without collapsing
        expect_lit("a", 0, 0);
        expect_lit("", 0, 0);
        expect_lit("b", 0, 1);
        send_str("a,,b", 1);
        collapse = 1'b1;
        expect_lit("a", 0, 0);
        expect_lit("b", 0, 1);
        send_str("a,,b", 1);
        collapse = 1'b0;
        expect_lit("", 0, 1);
        send_str(",", 1);
        collapse = 1'b1;
        expect_lit("", 0, 1);
        send_str(",", 1);
        collapse = 1'b0;
        drain_and_sync();

        // Truncation then a clean string
        expect_lit("abcd", 1, 1);
        expect_lit("xy", 0, 1);
        send_str("abcdefg", 1);
        send_str("xy", 1);
        drain_and_sync();

        // Backpressure: FIFO fills, input stalls, then drains in order
        ready_cmd = 1'b0;
        expect_lit("a", 0, 0);
        expect_lit("b", 0, 0);
        expect_lit("c", 0, 0);
        expect_lit("d", 0, 0);
        expect_lit("e", 0, 0);
        send_str("a,b,c,d,", 0);
        fork
            send_str("e,", 0);
            begin
                repeat (8) @(posedge clk);
                #1;
                ready_cmd = 1'b1;
            end
        join
        drain_and_sync();

        // Reset mid-string discards queued and partial tokens
        ready_cmd = 1'b0;
        send_str("ab,c", 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready_cmd = 1'b1;
        expect_lit("z", 0, 1);
        send_str("z", 1);
        drain_and_sync();

`ifdef SVLIB_STR_TOKENIZER_STATS_EN
        // Three tokens, one truncated, then a clear coinciding with a push
        send_str("abcdefg,x,y", 1);
        drain_and_sync();
        stats_clr = 1'b1;
        send_byte(",", 1'b1);
        stats_clr = 1'b0;
        drain_and_sync();
`endif

        // Randomized strings with random delimiter, collapse, gaps and consumer stalls
        rand_mode = 1;
        gap_en = 1;
        for (int s = 0; s < 150; s++) begin
            delim_char = ($urandom_range(0, 1) == 0) ? 8'h2C : 8'h3B;
            collapse   = $urandom_range(0, 1) == 1;
            n = $urandom_range(1, 10);
            for (int j = 0; j < n; j++) begin
`ifdef SVLIB_STR_TOKENIZER_STATS_EN
                stats_clr = ($urandom_range(0, 15) == 0);
`endif
                send_byte(alph[$urandom_range(0, 3)], j == n - 1);
            end
`ifdef SVLIB_STR_TOKENIZER_STATS_EN
            stats_clr = 1'b0;
`endif
        end
        rand_mode = 0;
        gap_en = 0;
        ready_cmd = 1'b1;
        drain_and_sync();

        @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
